// File: rtl/aes_load_sequencer_if.sv
// Word streams between the SoC bus shim and aes_load_sequencer.
// The master modport is the sequencer's side; the slave modport is the shim's side.
interface aes_load_sequencer_if;
    logic [31:0] s_data;
    logic        s_tag;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;

    modport master (
        input  s_data, s_tag, s_valid, m_ready,
        output s_ready, m_data, m_valid, m_last
    );

    modport slave (
        output s_data, s_tag, s_valid, m_ready,
        input  s_ready, m_data, m_valid, m_last
    );
endinterface

// File: rtl/aes_load_sequencer.sv
// Word-serial front end for aes_cipher_top: assembles key/plaintext words, launches
// the core, waits for done with a timeout and streams the ciphertext back out.
module aes_load_sequencer #(
    parameter int DONE_TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_load_sequencer_if.master bus,
    output logic                 ld,
    output logic [127:0]         key,
    output logic [127:0]         text_in,
    input  logic                 done,
    input  logic [127:0]         text_out,
    output logic                 key_valid,
    output logic                 busy,
    output logic                 err_proto,
    output logic                 err_nokey,
    output logic                 err_timeout
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] DRAIN  = 2'd3;

    localparam logic [7:0] TMO_LAST = 8'(DONE_TIMEOUT - 1);

    logic [1:0]   state;
    logic [1:0]   state_next;
    logic [1:0]   wcnt;
    logic [1:0]   slot;
    logic [1:0]   ocnt;
    logic         blk_tag;
    logic         s_ready_q;
    logic         accept;
    logic         tag_switch;
    logic         blk_done;
    logic         m_fire;
    logic [7:0]   tcnt;
    logic [127:0] obuf;

    function automatic logic [127:0] insert_word(input logic [127:0] r,
                                                 input logic [1:0]   s,
                                                 input logic [31:0]  w);
        logic [127:0] v;
        v = r;
        case (s)
            2'd0:    v[127:96] = w;
            2'd1:    v[95:64]  = w;
            2'd2:    v[63:32]  = w;
            default: v[31:0]   = w;
        endcase
        return v;
    endfunction

    // A tag change mid-block restarts assembly, so the offending word lands in slot 0.
    assign accept     = bus.s_valid && s_ready_q && (state == IDLE);
    assign tag_switch = (wcnt != 2'd0) && (bus.s_tag != blk_tag);
    assign slot       = tag_switch ? 2'd0 : wcnt;
    assign blk_done   = accept && (slot == 2'd3);
    assign m_fire     = (state == DRAIN) && bus.m_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (blk_done && !bus.s_tag && key_valid) state_next = LAUNCH;
            LAUNCH:  state_next = WAIT;
            WAIT: begin
                if (done)                   state_next = DRAIN;
                else if (tcnt == TMO_LAST)  state_next = IDLE;
            end
            DRAIN:   if (m_fire && (ocnt == 2'd3)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            s_ready_q   <= 1'b0;
            wcnt        <= 2'd0;
            blk_tag     <= 1'b0;
            key_valid   <= 1'b0;
            err_proto   <= 1'b0;
            err_nokey   <= 1'b0;
            err_timeout <= 1'b0;
            tcnt        <= 8'd0;
            ocnt        <= 2'd0;
            obuf        <= '0;
        end else begin
            state     <= state_next;
            s_ready_q <= (state_next == IDLE);

            if (accept) begin
                if (tag_switch) begin
                    err_proto <= 1'b1;
                    if (blk_tag) key_valid <= 1'b0;
                end
                if (slot == 2'd0) blk_tag <= bus.s_tag;
                if (blk_done) begin
                    wcnt <= 2'd0;
                    if (bus.s_tag)       key_valid <= 1'b1;
                    else if (!key_valid) err_nokey <= 1'b1;
                end else begin
                    wcnt <= slot + 2'd1;
                end
            end

            // The timeout counter only runs while waiting on the core.
            if (state != WAIT) tcnt <= 8'd0;
            else               tcnt <= tcnt + 8'd1;

            if ((state == WAIT) && !done && (tcnt == TMO_LAST)) err_timeout <= 1'b1;
            if ((state == WAIT) && done) obuf <= text_out;
            if (m_fire) ocnt <= ocnt + 2'd1;
        end
    end

    // Key and plaintext are only written in IDLE, so they hold steady for the core.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key     <= '0;
            text_in <= '0;
        end else if (accept) begin
            if (bus.s_tag) key     <= insert_word(key, slot, bus.s_data);
            else           text_in <= insert_word(text_in, slot, bus.s_data);
        end
    end

    always_comb begin
        bus.m_data = obuf[127:96];
        case (ocnt)
            2'd0:    bus.m_data = obuf[127:96];
            2'd1:    bus.m_data = obuf[95:64];
            2'd2:    bus.m_data = obuf[63:32];
            default: bus.m_data = obuf[31:0];
        endcase
    end

    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = (state == DRAIN);
    assign bus.m_last  = (state == DRAIN) && (ocnt == 2'd3);
    assign ld          = (state == LAUNCH);
    assign busy        = (state != IDLE);

endmodule

// File: doc/aes_load_sequencer.md
# aes_load_sequencer

Word-serial front end for `aes_cipher_top`. It collects 32-bit key and plaintext words from a valid/ready stream and assembles them into 128-bit registers. It launches the core with a one-cycle `ld` pulse and waits for `done`, with a timeout. The ciphertext is then returned as four 32-bit words on a valid/ready output stream. It sits between the SoC bus shim and the cipher core, and is the only driver of the core's `ld`, `key` and `text_in` inputs.

## Interface
- `DONE_TIMEOUT`, default 32: number of cycles in WAIT without `done` before the launch is aborted. Range 13..255.
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `s_data`  in  32  input word.
- `s_tag`  in  1  0 = plaintext word, 1 = key word.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  block accepts the input word.
- `m_data`  out  32  ciphertext word.
- `m_valid`  out  1  ciphertext word valid.
- `m_last`  out  1  marks the 4th ciphertext word.
- `m_ready`  in  1  downstream accepts the ciphertext word.
- `ld`  out  1  load strobe to `aes_cipher_top`.
- `key`  out  128  key register, drives the core.
- `text_in`  out  128  plaintext register, drives the core.
- `done`  in  1  core completion pulse.
- `text_out`  in  128  core result, sampled in the cycle `done`=1.
- `key_valid`  out  1  a complete key is loaded.
- `busy`  out  1  state is not IDLE.
- `err_proto`  out  1  sticky: tag changed mid-block.
- `err_nokey`  out  1  sticky: plaintext block completed with no key loaded.
- `err_timeout`  out  1  sticky: `done` not seen within `DONE_TIMEOUT`.

## Operation
- **States:** IDLE, LAUNCH, WAIT, DRAIN.
- **Reset values:** state IDLE; all outputs 0, including `key`, `text_in`, `m_data`, the word counter and all error flags.
- **IDLE:**
  - `s_ready`=1.
  - Each accepted word is written to slot `wcnt` (0..3) of the register selected by the block tag. Word 0 goes to [127:96]; word 3 goes to [31:0].
  - The block tag is latched from word 0.
- **Tag change mid-block:** if `wcnt`≠0 and `s_tag` differs from the block tag:
  - set `err_proto`;
  - discard the partial block;
  - treat the current word as word 0 of a new block with the new tag.
  - A discarded key block clears `key_valid`. Register bits already written are not restored.
- **Completed key block (tag 1):** sets `key_valid`, resets `wcnt`, stays in IDLE. The key persists across any number of plaintext blocks until replaced.
- **Completed plaintext block (tag 0):**
  - With `key_valid`=1: go to LAUNCH.
  - With `key_valid`=0: set `err_nokey`, discard the block, stay in IDLE.
- **LAUNCH:** `ld`=1 for exactly one cycle, then go to WAIT. `key` and `text_in` stay unchanged from LAUNCH until DRAIN exits.
- **WAIT:**
  - A timeout counter starts at 0 and increments each cycle.
  - On `done`=1: capture `text_out` into the output buffer, go to DRAIN.
  - If the counter reaches `DONE_TIMEOUT`-1 with `done`=0: set `err_timeout`, go to IDLE, present no output.
  - A `done` seen outside WAIT is ignored.
- **DRAIN:**
  - Present buffer words [127:96], [95:64], [63:32], [31:0] in order.
  - A word advances on `m_valid`&&`m_ready`.
  - `m_last`=1 on word 3.
  - After word 3 is accepted, go to IDLE.
- **Error flags:** sticky; cleared only by reset.

## Timing
- `s_ready` is a registered function of state: 1 only in IDLE. Words offered in other states stall without loss.
- Cycle sequence from plaintext completion to first output:
  - accepting the 4th plaintext word in cycle N → `ld`=1 in cycle N+1;
  - WAIT begins in cycle N+2;
  - `done` in cycle D → `m_valid`=1 with word 0 in cycle D+1.
- Throughput: with `m_ready` held at 1, one output word per cycle. `m_data` and `m_last` are held stable while `m_valid`=1 and `m_ready`=0.
- DRAIN exit: word 3 accepted in cycle E → `s_ready`=1 in cycle E+1.
- Back-to-back: with `m_ready`=1 and a prompt source, a plaintext-only block costs 4 (in) + 1 (LAUNCH) + core latency + 4 (out) cycles.
- Reset asserted mid-operation: every output returns to its reset value immediately and asynchronously, including `ld`. A core operation in flight is abandoned; its later `done` arrives outside WAIT and is ignored.

## Test plan
- **FIPS-197 single block:** key words 00010203, 04050607, 08090a0b, 0c0d0e0f (tag 1), then plaintext 00112233, 44556677, 8899aabb, ccddeeff (tag 0). Required: one `ld` pulse, then `m_data` = 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a with `m_last` on the 4th word.
- **Key reuse with backpressure:** same key, two plaintext blocks back-to-back, `m_ready` toggling 1/0. Required: two correct 4-word bursts, no word dropped or duplicated, data held stable while stalled.
- **No key:** plaintext block after reset. Required: `err_nokey`=1, no `ld`, no `m_valid`, `s_ready` stays 1.
- **Tag switch:** 2 key words, then 4 plaintext words. Required: `err_proto`=1, `key_valid`=0, then `err_nokey`=1 and no `ld`.
- **Timeout:** core model never asserts `done`. Required: `err_timeout`=1 exactly `DONE_TIMEOUT` cycles after WAIT entry, then IDLE, with no output.
- **Reset mid-DRAIN:** `rst`=0 after word 1 is accepted. Required: all outputs 0 asynchronously; after release, `key_valid`=0 and `s_ready`=1.
